mux_2x1: RTL and testbench
==========================

MUX_2X1 -- requirements
Module: mux_2x1

Interface
REQ-001 Parameter CNT_W, default 8: width of the select-toggle counter, legal range 2..16.
REQ-002 clk_in  input  1  rising-edge clock for all registered outputs.
REQ-003 rst_in  input  1  asynchronous, active-high reset.
REQ-004 d_in  input  2  data inputs: d_in[0] selected when sel_in=0, d_in[1] selected when sel_in=1.
REQ-005 sel_in  input  1  select.
REQ-006 d_out  output  1  combinational mux output.
REQ-007 d_out_q  output  1  registered copy of the mux result.
REQ-008 sel_q  output  1  registered copy of sel_in.
REQ-009 toggle_cnt  output  CNT_W  saturating count of sel_in transitions.
REQ-010 toggle_sat  output  1  high while toggle_cnt is all-ones.

Function
REQ-011 d_out SHALL equal d_in[sel_in] at all times.
- Purely combinational, zero latency.
- Independent of clk_in and rst_in, including during reset.
REQ-012 d_out SHALL follow any change on d_in or sel_in within the same delta/settle time, with no storage element in the path.
REQ-013 On each rising clk_in edge with rst_in low, d_out_q SHALL load d_in[sel_in] sampled at that edge (1-cycle latency).
REQ-014 On each rising clk_in edge with rst_in low, sel_q SHALL load sel_in.
REQ-015 A toggle event SHALL be defined as sel_in != sel_q at a rising clk_in edge.
REQ-016 On a toggle event, toggle_cnt SHALL increment by 1 unless it is already all-ones; otherwise it holds.
REQ-017 toggle_cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-018 toggle_sat SHALL be decoded from the toggle_cnt register, with no extra latency.
REQ-019 sel_in changes between clock edges SHALL NOT be counted; multiple changes within one cycle count at most once, and an even number of changes counts zero.
REQ-020 The first edge after reset SHALL compare sel_in against the reset value sel_q=0, so sel_in=1 at that edge counts as one toggle.
REQ-021 Simultaneous changes of d_in and sel_in at a clock edge SHALL be handled as follows:
- d_out_q takes the mux of the values sampled at that edge.
- The counter still evaluates the toggle.

Reset
REQ-022 While rst_in is high, the registered outputs SHALL be forced immediately, without waiting for a clock edge, to: d_out_q=0, sel_q=0, toggle_cnt=0, toggle_sat=0.
REQ-023 Registered outputs SHALL hold their reset values for as long as rst_in is high, regardless of clk_in activity.
REQ-024 Normal operation SHALL resume at the first rising clk_in edge after rst_in falls; synchronous release of rst_in is provided by the system.
REQ-025 Reset asserted mid-operation SHALL discard the counter value, and counting SHALL restart from 0 after release.

Verification
REQ-026 Combinational truth table, clock stopped: d_in=2'b10 with sel_in=0 -> d_out=0; sel_in=1 -> d_out=1; d_in=2'b01 with sel_in=0 -> d_out=1; sel_in=1 -> d_out=0.
REQ-027 Free-running toggles: d_in inverts every 50 ns and sel_in inverts every 40 ns for 500 ns -> at every instant d_out=d_in[sel_in], with no X after the initial assignment.
REQ-028 Registered path: d_in=2'b10 and sel_in=1 applied just before an edge -> d_out_q=1 after that edge and 0 before it.
REQ-029 Counter saturation: CNT_W=2, sel_in toggled on 5 consecutive edges -> toggle_cnt goes 1,2,3,3,3, and toggle_sat rises with the third toggle.
REQ-030 Async reset: rst_in pulsed high between edges with toggle_cnt=3 -> toggle_cnt=0, sel_q=0 and d_out_q=0 immediately while d_out keeps tracking d_in[sel_in]; with sel_in=1 at the first edge after release -> toggle_cnt=1.

Source files
------------

// File: rtl/mux_2x1.sv
// 2:1 multiplexer with a registered copy of its result, a registered copy of
// the select, and a saturating counter of select transitions seen at clock
// edges. The combinational output is independent of clock and reset.
module mux_2x1 #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [1:0]       d_in,
  input  logic             sel_in,
  output logic             d_out,
  output logic             d_out_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             toggle_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic mux_val;
  logic toggle_evt;
  logic cnt_full;

  // Pure mux: no storage element anywhere between d_in/sel_in and d_out.
  assign mux_val = d_in[sel_in];
  assign d_out   = mux_val;

  // A toggle is a select that differs from the value captured at the previous
  // edge, so glitches between edges are invisible and an even number of
  // intra-cycle changes cancels out.
  assign toggle_evt = sel_in ^ sel_q;

  // Saturation flag decoded straight from the counter register.
  assign cnt_full   = (toggle_cnt == CNT_MAX);
  assign toggle_sat = cnt_full;

  // Registered mux result and select copy; forced low immediately on reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      d_out_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      d_out_q <= mux_val;
      sel_q   <= sel_in;
    end
  end

  // Toggle counter: climbs by one per toggle and parks at all-ones.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      toggle_cnt <= '0;
    end else if (toggle_evt && !cnt_full) begin
      toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_2x1.sv
// Directed and randomized bench for mux_2x1. Two instances share the inputs:
// one at the default counter width and one at width 2 for saturation.
module tb_mux_2x1;

  logic       clk_in  = 1'b0;
  logic       rst_in  = 1'b1;
  logic [1:0] d_in    = 2'b00;
  logic       sel_in  = 1'b0;
  bit         clk_run = 1'b0;

  logic       d_out_a, d_out_q_a, sel_q_a, toggle_sat_a;
  logic [7:0] toggle_cnt_a;
  logic       d_out_b, d_out_q_b, sel_q_b, toggle_sat_b;
  logic [1:0] toggle_cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  logic m_dq;
  logic m_selq;
  int   m_cnt_a;
  int   m_cnt_b;
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  mux_2x1 dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(d_in), .sel_in(sel_in),
    .d_out(d_out_a), .d_out_q(d_out_q_a), .sel_q(sel_q_a),
    .toggle_cnt(toggle_cnt_a), .toggle_sat(toggle_sat_a)
  );

  mux_2x1 #(.CNT_W(2)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(d_in), .sel_in(sel_in),
    .d_out(d_out_b), .d_out_q(d_out_q_b), .sel_q(sel_q_b),
    .toggle_cnt(toggle_cnt_b), .toggle_sat(toggle_sat_b)
  );

  // Gated clock so the combinational checks can run with the clock stopped.
  always begin
    #5;
    if (clk_run) clk_in = ~clk_in;
  end

  // Behavioural model: remember the select seen at the last edge and count
  // differences, clipping at the counter's maximum.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_dq    <= 1'b0;
      m_selq  <= 1'b0;
      m_cnt_a <= 0;
      m_cnt_b <= 0;
    end else begin
      m_dq   <= d_in[sel_in];
      m_selq <= sel_in;
      if (sel_in != m_selq) begin
        m_cnt_a <= (m_cnt_a + 1 > MAX_A) ? MAX_A : m_cnt_a + 1;
        m_cnt_b <= (m_cnt_b + 1 > MAX_B) ? MAX_B : m_cnt_b + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    check_output({tag, " d_out_a"}, 16'(d_out_a), 16'(d_in[sel_in]));
    check_output({tag, " d_out_b"}, 16'(d_out_b), 16'(d_in[sel_in]));
  endtask

  task automatic check_all(input string tag);
    check_comb(tag);
    check_output({tag, " d_out_q_a"}, 16'(d_out_q_a), 16'(m_dq));
    check_output({tag, " d_out_q_b"}, 16'(d_out_q_b), 16'(m_dq));
    check_output({tag, " sel_q_a"}, 16'(sel_q_a), 16'(m_selq));
    check_output({tag, " sel_q_b"}, 16'(sel_q_b), 16'(m_selq));
    check_output({tag, " cnt_a"}, 16'(toggle_cnt_a), 16'(m_cnt_a));
    check_output({tag, " cnt_b"}, 16'(toggle_cnt_b), 16'(m_cnt_b));
    check_output({tag, " sat_a"}, 16'(toggle_sat_a), 16'(m_cnt_a == MAX_A));
    check_output({tag, " sat_b"}, 16'(toggle_sat_b), 16'(m_cnt_b == MAX_B));
  endtask

  task automatic apply_stimulus(input logic [1:0] d, input logic s);
    d_in   = d;
    sel_in = s;
  endtask

  initial begin
    logic [1:0] d_init;
    int         exp_cnt [5];
    logic       exp_sat [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    exp_sat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset held, clock stopped: registered outputs at reset values.
    #2;
    check_output("reset d_out_q", 16'(d_out_q_a), 16'd0);
    check_output("reset sel_q", 16'(sel_q_a), 16'd0);
    check_output("reset cnt", 16'(toggle_cnt_a), 16'd0);
    check_output("reset sat", 16'(toggle_sat_b), 16'd0);

    // Truth table with the clock stopped (and reset still asserted).
    apply_stimulus(2'b10, 1'b0); #1;
    check_output("tt 10/0", 16'(d_out_a), 16'd0);
    apply_stimulus(2'b10, 1'b1); #1;
    check_output("tt 10/1", 16'(d_out_a), 16'd1);
    apply_stimulus(2'b01, 1'b0); #1;
    check_output("tt 01/0", 16'(d_out_a), 16'd1);
    apply_stimulus(2'b01, 1'b1); #1;
    check_output("tt 01/1", 16'(d_out_a), 16'd0);

    // Free-running toggles: d_in inverts every 50 ns, sel_in every 40 ns.
    d_init = 2'b10;
    for (int t = 0; t < 500; t += 5) begin
      apply_stimulus(((t / 50) % 2 == 1) ? ~d_init : d_init,
                     ((t / 40) % 2 == 1));
      #1;
      check_comb("free run");
      #4;
    end

    // Release reset, then a registered-path transaction on the first edge.
    apply_stimulus(2'b10, 1'b1);
    rst_in = 1'b0;
    #1;
    check_output("pre-edge d_out_q", 16'(d_out_q_a), 16'd0);
    clk_run = 1'b1;
    @(posedge clk_in); #1;
    check_output("post-edge d_out_q", 16'(d_out_q_a), 16'd1);
    check_output("first edge cnt", 16'(toggle_cnt_a), 16'd1);
    check_all("first edge");

    // Reset held across a running clock edge.
    @(negedge clk_in);
    rst_in = 1'b1;
    apply_stimulus(2'b00, 1'b0);
    #1;
    check_all("reset mid-run");
    @(posedge clk_in); #1;
    check_output("reset hold cnt", 16'(toggle_cnt_a), 16'd0);
    check_output("reset hold d_out_q", 16'(d_out_q_a), 16'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Saturation at width 2: five consecutive toggles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      apply_stimulus(2'b11, ~sel_in);
      @(posedge clk_in); #1;
      check_output("sat seq cnt_b", 16'(toggle_cnt_b), 16'(exp_cnt[i]));
      check_output("sat seq sat_b", 16'(toggle_sat_b), 16'(exp_sat[i]));
      check_all("sat seq");
    end

    // Async reset between edges with counter at 3.
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    check_output("async cnt_b", 16'(toggle_cnt_b), 16'd0);
    check_output("async sel_q", 16'(sel_q_b), 16'd0);
    check_output("async d_out_q", 16'(d_out_q_b), 16'd0);
    apply_stimulus(2'b01, 1'b0);
    #1;
    check_output("async d_out", 16'(d_out_b), 16'd1);
    rst_in = 1'b0;
    apply_stimulus(2'b01, 1'b1);
    @(posedge clk_in); #1;
    check_output("post-release cnt_b", 16'(toggle_cnt_b), 16'd1);
    check_all("post-release");

    // Randomized traffic with intra-cycle select glitches and reset pulses.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_in);
      apply_stimulus(2'($urandom), 1'($urandom));
      #1;
      check_comb("rand comb");
      if ($urandom_range(0, 3) == 0) begin
        sel_in = ~sel_in; #1;
        check_comb("rand glitch");
        sel_in = ~sel_in;
        if ($urandom_range(0, 1) == 0) begin
          #1;
          sel_in = ~sel_in;
        end
      end
      if ($urandom_range(0, 24) == 0) begin
        rst_in = 1'b1; #1;
        check_all("rand reset");
        rst_in = 1'b0;
      end
      @(posedge clk_in); #1;
      check_all("rand edge");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
